// File: rtl/ekf_stage_scheduler_if.sv
// ekf_stage_scheduler_if
//   Groups the handshake and operand signals of the EKF stage scheduler.
//   slave  : the scheduler itself. It accepts sensor packets, drives stage
//            requests and operands.
//   master : the environment. This is the sensor front end plus PE_config.
// Signals:
//   odo_val/odo_rdy, odo_v, odo_w          odometry packet handshake
//   obs_val/obs_rdy, obs_id, obs_r, obs_b  observation packet handshake
//   stage_val (one-hot), stage_rdy         stage request / PE_config status
//   cur_v, cur_w, cur_id, cur_r, cur_b     operands for the running stage
//   lm_cnt, stage_done, obs_err            landmark count and event pulses
interface ekf_stage_scheduler_if #(
  parameter int RSA_DW = 16,
  parameter int LM_IDW = 9
);
  logic              odo_val;
  logic              odo_rdy;
  logic [RSA_DW-1:0] odo_v;
  logic [RSA_DW-1:0] odo_w;
  logic              obs_val;
  logic              obs_rdy;
  logic [LM_IDW-1:0] obs_id;
  logic [RSA_DW-1:0] obs_r;
  logic [RSA_DW-1:0] obs_b;
  logic [2:0]        stage_val;
  logic [2:0]        stage_rdy;
  logic [RSA_DW-1:0] cur_v;
  logic [RSA_DW-1:0] cur_w;
  logic [LM_IDW-1:0] cur_id;
  logic [RSA_DW-1:0] cur_r;
  logic [RSA_DW-1:0] cur_b;
  logic [LM_IDW-1:0] lm_cnt;
  logic              stage_done;
  logic              obs_err;

  modport master (
    output odo_val, odo_v, odo_w, obs_val, obs_id, obs_r, obs_b, stage_rdy,
    input  odo_rdy, obs_rdy, stage_val, cur_v, cur_w, cur_id, cur_r, cur_b,
           lm_cnt, stage_done, obs_err
  );

  modport slave (
    input  odo_val, odo_v, odo_w, obs_val, obs_id, obs_r, obs_b, stage_rdy,
    output odo_rdy, obs_rdy, stage_val, cur_v, cur_w, cur_id, cur_r, cur_b,
           lm_cnt, stage_done, obs_err
  );
endinterface

// File: rtl/ekf_stage_scheduler.sv
// ekf_stage_scheduler
//   This block sits upstream of PE_config and sequences its EKF stages.
//   Odometry is latched into a single pending register. Observations are
//   queued in a small FIFO.
//   An IDLE/ISSUE/WAIT_DONE FSM chooses the next stage. PRD is chosen when
//   odometry is pending. NEW or UPD is chosen from the FIFO head. The FSM
//   issues the chosen stage over stage_val/stage_rdy and then waits until
//   PE_config reports that it is ready again.
// Ports:
//   clk      clock
//   sys_rst  synchronous active-high reset
//   bus      ekf_stage_scheduler_if.slave (see interface header)
module ekf_stage_scheduler #(
  parameter int RSA_DW       = 16,
  parameter int LM_IDW       = 9,
  parameter int MAX_LANDMARK = 500,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  ekf_stage_scheduler_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  // The encoding is identical to the one-hot stage_val code seen by PE_config.
  typedef enum logic [2:0] {
    STG_NONE = 3'b000,
    STG_PRD  = 3'b001,
    STG_NEW  = 3'b010,
    STG_UPD  = 3'b100
  } stage_e;

  typedef struct packed {
    logic [LM_IDW-1:0] id;
    logic [RSA_DW-1:0] r;
    logic [RSA_DW-1:0] b;
  } obs_t;

  state_e            state_q, state_d;
  stage_e            stage_q, stage_d;
  logic              odo_pend_q;
  logic [RSA_DW-1:0] cur_v_q, cur_w_q;
  logic [LM_IDW-1:0] lm_cnt_q;
  logic              stage_done_q, obs_err_q;

  obs_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  obs_t              head;
  logic              fifo_empty, fifo_full;

  logic odo_hs, obs_push, fifo_pop, drop, done, clr_odo, inc_lm;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr_q];

  // Odometry is refused while it is pending and also for the whole PRD
  // stage. This keeps cur_v/cur_w stable under the PRD nonlinear path.
  assign bus.odo_rdy = !sys_rst && !odo_pend_q &&
                       !(state_q != IDLE && stage_q == STG_PRD);
  assign bus.obs_rdy = !sys_rst && !fifo_full;
  assign odo_hs      = bus.odo_val && bus.odo_rdy;
  assign obs_push    = bus.obs_val && bus.obs_rdy;

  assign bus.stage_val  = (!sys_rst && state_q == ISSUE) ? stage_q : STG_NONE;
  assign bus.cur_v      = cur_v_q;
  assign bus.cur_w      = cur_w_q;
  // Head fields read as zero while the FIFO is empty or in reset. This avoids
  // exposing stale entries and entries that were never written.
  assign bus.cur_id     = (sys_rst || fifo_empty) ? '0 : head.id;
  assign bus.cur_r      = (sys_rst || fifo_empty) ? '0 : head.r;
  assign bus.cur_b      = (sys_rst || fifo_empty) ? '0 : head.b;
  assign bus.lm_cnt     = lm_cnt_q;
  assign bus.stage_done = stage_done_q;
  assign bus.obs_err    = obs_err_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    drop    = 1'b0;
    done    = 1'b0;
    clr_odo = 1'b0;
    inc_lm  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (odo_pend_q) begin
          stage_d = STG_PRD;
          state_d = ISSUE;
        end else if (!fifo_empty) begin
          if (head.id < lm_cnt_q) begin
            stage_d = STG_UPD;
            state_d = ISSUE;
          end else if (head.id == lm_cnt_q &&
                       lm_cnt_q < LM_IDW'(MAX_LANDMARK)) begin
            stage_d = STG_NEW;
            state_d = ISSUE;
          end else begin
            // The id skips ahead of the map, or the map is full.
            drop = 1'b1;
          end
        end
      end
      ISSUE: begin
        // PE_config reports that it is busy, which means it took the request.
        if (bus.stage_rdy == 3'b000) begin
          state_d = WAIT_DONE;
          clr_odo = (stage_q == STG_PRD);
        end
      end
      WAIT_DONE: begin
        if (bus.stage_rdy == 3'b111) begin
          done    = 1'b1;
          inc_lm  = (stage_q == STG_NEW);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = drop || (done && stage_q != STG_PRD);

  // NOTE: state registers use non-blocking assignment only. All registers then
  // update together at the edge, whatever order the always blocks evaluate in.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      stage_q <= STG_NONE;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      odo_pend_q   <= 1'b0;
      cur_v_q      <= '0;
      cur_w_q      <= '0;
      lm_cnt_q     <= '0;
      stage_done_q <= 1'b0;
      obs_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      stage_done_q <= done;
      obs_err_q    <= drop;
      if (odo_hs) begin
        odo_pend_q <= 1'b1;
        cur_v_q    <= bus.odo_v;
        cur_w_q    <= bus.odo_w;
      end else if (clr_odo) begin
        odo_pend_q <= 1'b0;
      end
      if (inc_lm) lm_cnt_q <= lm_cnt_q + 1'b1;
      if (obs_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({obs_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset. Resetting the pointers and the count
  // already empties the FIFO, and no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (obs_push) fifo_mem[wr_ptr_q] <= '{id: bus.obs_id, r: bus.obs_r, b: bus.obs_b};
  end

endmodule

// File: tb/tb_ekf_stage_scheduler.sv
// tb_ekf_stage_scheduler
//   Directed bench for ekf_stage_scheduler. Inputs are driven and outputs are
//   sampled on the falling clock edge. Expected values are hand-derived from
//   the stage-sequencing rules.
module tb_ekf_stage_scheduler;

  logic clk = 1'b0;
  logic sys_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ekf_stage_scheduler_if #(.RSA_DW(16), .LM_IDW(9)) bus ();

  ekf_stage_scheduler #(
    .RSA_DW(16), .LM_IDW(9), .MAX_LANDMARK(500), .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_obs(input logic [8:0] id, input logic [15:0] r, input logic [15:0] b);
    bus.obs_val = 1'b1;
    bus.obs_id  = id;
    bus.obs_r   = r;
    bus.obs_b   = b;
  endtask

  // The wait for the stage request is bounded. On a timeout, stage_val reads
  // as zero, the first check reports it and the run continues.
  task automatic wait_issue();
    int n = 0;
    while (bus.stage_val == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Serve one stage. PE_config accepts the request, stays busy for two
  // cycles, then reports ready again.
  task automatic serve(input string tag, input logic [2:0] exp_stage,
                       input logic [8:0] exp_id, input logic [8:0] exp_lm);
    wait_issue();
    check({tag, "_val"}, bus.stage_val, exp_stage);
    check({tag, "_id"}, bus.cur_id, exp_id);
    bus.stage_rdy = 3'b000;
    @(negedge clk);
    check({tag, "_acc"}, bus.stage_val, 3'b000);
    @(negedge clk);
    bus.stage_rdy = 3'b111;
    @(negedge clk);
    check({tag, "_done"}, bus.stage_done, 1'b1);
    check({tag, "_lm"}, bus.lm_cnt, exp_lm);
    @(negedge clk);
    check({tag, "_pulse"}, bus.stage_done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst       = 1'b1;
    bus.odo_val   = 1'b0;
    bus.odo_v     = '0;
    bus.odo_w     = '0;
    bus.obs_val   = 1'b0;
    bus.obs_id    = '0;
    bus.obs_r     = '0;
    bus.obs_b     = '0;
    bus.stage_rdy = 3'b111;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_odo_rdy", bus.odo_rdy, 1'b0);
    check("rst_obs_rdy", bus.obs_rdy, 1'b0);
    check("rst_stage_val", bus.stage_val, 3'b000);
    check("rst_lm_cnt", bus.lm_cnt, 9'd0);
    check("rst_cur_v", bus.cur_v, 16'h0);
    sys_rst = 1'b0;
    @(negedge clk);
    check("post_rst_odo_rdy", bus.odo_rdy, 1'b1);
    check("post_rst_obs_rdy", bus.obs_rdy, 1'b1);
    check("post_rst_done", bus.stage_done, 1'b0);
    check("post_rst_err", bus.obs_err, 1'b0);

    // PRD: odometry beat, request two cycles later, five busy cycles
    bus.odo_val = 1'b1;
    bus.odo_v   = 16'h0100;
    bus.odo_w   = 16'h0020;
    @(negedge clk);
    bus.odo_val = 1'b0;
    check("prd_decide_val", bus.stage_val, 3'b000);
    check("prd_pend_rdy", bus.odo_rdy, 1'b0);
    @(negedge clk);
    check("prd_val", bus.stage_val, 3'b001);
    check("prd_cur_v", bus.cur_v, 16'h0100);
    check("prd_cur_w", bus.cur_w, 16'h0020);
    // The next beat must not overwrite the operands while PRD runs.
    bus.odo_val = 1'b1;
    bus.odo_v   = 16'h0BAD;
    bus.odo_w   = 16'h0BAD;
    @(negedge clk);
    check("prd_val_held", bus.stage_val, 3'b001);
    bus.stage_rdy = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prd_busy_val", bus.stage_val, 3'b000);
      check("prd_busy_done", bus.stage_done, 1'b0);
      check("prd_busy_cur_v", bus.cur_v, 16'h0100);
      check("prd_busy_odo_rdy", bus.odo_rdy, 1'b0);
    end
    bus.odo_val   = 1'b0;
    bus.stage_rdy = 3'b111;
    @(negedge clk);
    check("prd_done", bus.stage_done, 1'b1);
    check("prd_done_cur_v", bus.cur_v, 16'h0100);
    check("prd_done_odo_rdy", bus.odo_rdy, 1'b1);
    check("prd_done_lm", bus.lm_cnt, 9'd0);
    @(negedge clk);
    check("prd_pulse", bus.stage_done, 1'b0);
    check("prd_idle_val", bus.stage_val, 3'b000);

    // NEW, NEW, UPD from ids 0, 1, 0
    drive_obs(9'd0, 16'h0011, 16'h0022);
    @(negedge clk);
    drive_obs(9'd1, 16'h0033, 16'h0044);
    @(negedge clk);
    drive_obs(9'd0, 16'h0055, 16'h0066);
    check("new0_val_2cyc", bus.stage_val, 3'b010);
    check("new0_cur_r", bus.cur_r, 16'h0011);
    check("new0_cur_b", bus.cur_b, 16'h0022);
    @(negedge clk);
    bus.obs_val = 1'b0;
    serve("new0", 3'b010, 9'd0, 9'd1);
    serve("new1", 3'b010, 9'd1, 9'd2);
    serve("upd0", 3'b100, 9'd0, 9'd2);
    @(negedge clk);
    check("seq_empty_val", bus.stage_val, 3'b000);
    check("seq_empty_rdy", bus.obs_rdy, 1'b1);

    // Dropped observation: id 5 while lm_cnt = 2
    drive_obs(9'd5, 16'h0077, 16'h0088);
    @(negedge clk);
    bus.obs_val = 1'b0;
    check("drop_err_early", bus.obs_err, 1'b0);
    @(negedge clk);
    check("drop_err", bus.obs_err, 1'b1);
    check("drop_val", bus.stage_val, 3'b000);
    check("drop_lm", bus.lm_cnt, 9'd2);
    @(negedge clk);
    check("drop_err_pulse", bus.obs_err, 1'b0);
    check("drop_val2", bus.stage_val, 3'b000);
    check("drop_rdy", bus.obs_rdy, 1'b1);

    // FIFO full: four pushes while PE_config is busy, then a fifth push
    bus.stage_rdy = 3'b000;
    drive_obs(9'd2, 16'h0102, 16'h0202);
    @(negedge clk);
    check("full_rdy1", bus.obs_rdy, 1'b1);
    drive_obs(9'd1, 16'h0101, 16'h0201);
    @(negedge clk);
    drive_obs(9'd0, 16'h0100, 16'h0200);
    @(negedge clk);
    check("full_rdy3", bus.obs_rdy, 1'b1);
    drive_obs(9'd3, 16'h0103, 16'h0203);
    @(negedge clk);
    check("full_rdy4", bus.obs_rdy, 1'b0);
    drive_obs(9'd4, 16'h0104, 16'h0204);
    @(negedge clk);
    check("full_rdy_hold", bus.obs_rdy, 1'b0);
    check("full_no_done", bus.stage_done, 1'b0);
    bus.stage_rdy = 3'b111;
    @(negedge clk);
    check("full_new2_done", bus.stage_done, 1'b1);
    check("full_new2_lm", bus.lm_cnt, 9'd3);
    check("full_pop_rdy", bus.obs_rdy, 1'b1);
    @(negedge clk);
    check("full_fifth_taken", bus.obs_rdy, 1'b0);
    bus.obs_val = 1'b0;
    serve("upd1", 3'b100, 9'd1, 9'd3);
    serve("upd0b", 3'b100, 9'd0, 9'd3);
    serve("new3", 3'b010, 9'd3, 9'd4);
    serve("new4", 3'b010, 9'd4, 9'd5);

    // Odometry and an observation arrive together: PRD goes first
    bus.odo_val = 1'b1;
    bus.odo_v   = 16'h0200;
    bus.odo_w   = 16'h0040;
    drive_obs(9'd5, 16'h0105, 16'h0205);
    @(negedge clk);
    bus.odo_val = 1'b0;
    bus.obs_val = 1'b0;
    serve("both_prd", 3'b001, 9'd5, 9'd5);
    check("both_cur_v", bus.cur_v, 16'h0200);
    serve("both_new5", 3'b010, 9'd5, 9'd6);

    // Reset during WAIT_DONE of a NEW
    drive_obs(9'd6, 16'h0106, 16'h0206);
    @(negedge clk);
    bus.obs_val = 1'b0;
    wait_issue();
    check("rst_mid_issue", bus.stage_val, 3'b010);
    bus.stage_rdy = 3'b000;
    @(negedge clk);
    check("rst_mid_wait_val", bus.stage_val, 3'b000);
    sys_rst       = 1'b1;
    bus.stage_rdy = 3'b111;
    @(negedge clk);
    check("rst_mid_val", bus.stage_val, 3'b000);
    check("rst_mid_lm", bus.lm_cnt, 9'd0);
    check("rst_mid_done", bus.stage_done, 1'b0);
    check("rst_mid_odo_rdy", bus.odo_rdy, 1'b0);
    check("rst_mid_obs_rdy", bus.obs_rdy, 1'b0);
    check("rst_mid_cur_v", bus.cur_v, 16'h0);
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_after_done", bus.stage_done, 1'b0);
      check("rst_after_val", bus.stage_val, 3'b000);
      check("rst_after_err", bus.obs_err, 1'b0);
      check("rst_after_rdy", bus.obs_rdy, 1'b1);
    end

    // Normal operation after the reset
    drive_obs(9'd0, 16'h0300, 16'h0400);
    @(negedge clk);
    bus.obs_val = 1'b0;
    serve("recover_new0", 3'b010, 9'd0, 9'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
